ram32_initiator: RTL and testbench

- Initiator-side controller that drives the 1RW+1R 64-bit, 32-entry, byte-write-enabled register-file RAM macro.
- After reset it initialises every RAM entry, then accepts independent write and read requests over valid/ready.
- It drives the macro's port 0 (writes) and port 1 (reads) and returns read data on a response channel.
- It sits between core register-file logic and the RAM macro.

---
 rtl/ram32_pkg.sv | 21 ++
 rtl/ram32_initiator_if.sv | 27 ++
 rtl/ram32_bypass_merge.sv | 38 +++
 rtl/ram32_initiator.sv | 122 ++++++++++++
 tb/tb_ram32_initiator.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram32_pkg.sv
// Shared types and constants for the ram32 register-file initiator.
package ram32_pkg;
  localparam int RAM32_DATA_W = 64;
  localparam int RAM32_SEL_W  = 8;
  localparam int RAM32_BITS   = 5;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Per byte: take the new byte where sel is set, else keep the old byte.
  function automatic logic [RAM32_DATA_W-1:0] byte_merge(
    input logic [RAM32_SEL_W-1:0]  sel,
    input logic [RAM32_DATA_W-1:0] nw,
    input logic [RAM32_DATA_W-1:0] old
  );
    logic [RAM32_DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < RAM32_SEL_W; i++)
      if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/ram32_initiator_if.sv
// Request/response channels between the register-file core and the initiator.
interface ram32_initiator_if
  import ram32_pkg::*;
#(
  parameter int BITS = RAM32_BITS
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [BITS-1:0]         wr_addr;
  logic [RAM32_SEL_W-1:0]  wr_sel;
  logic [RAM32_DATA_W-1:0] wr_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [BITS-1:0]         rd_addr;
  logic                    rsp_valid;
  logic [RAM32_DATA_W-1:0] rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_sel, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_sel, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram32_bypass_merge.sv
// Write-to-read bypass: remembers a same-cycle same-address write and folds
// its enabled bytes over the macro read data one cycle later.
module ram32_bypass_merge
  import ram32_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    hit,
  input  logic [RAM32_SEL_W-1:0]  sel,
  input  logic [RAM32_DATA_W-1:0] data,
  input  logic [RAM32_DATA_W-1:0] rdata,
  output logic [RAM32_DATA_W-1:0] merged
);
  logic                    hit_q;
  logic [RAM32_SEL_W-1:0]  sel_q;
  logic [RAM32_DATA_W-1:0] data_q;

  // Capture the colliding write alongside the read it shadows.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_q  <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      hit_q <= hit;
      if (hit) begin
        sel_q  <= sel;
        data_q <= data;
      end
    end
  end

  // Macro data carries the pre-write value; overlay the written bytes.
  always_comb begin
    merged = rdata;
    if (hit_q) merged = byte_merge(sel_q, data_q, rdata);
  end
endmodule

// File: rtl/ram32_initiator.sv
// Initiator for the 1RW+1R 64b x 2**BITS byte-write register-file macro.
// Fills every entry with INIT_VAL after reset, then serves writes on port 0
// and reads on port 1 with a fixed one-cycle response.
// Optional: define RAM32_WR_BYPASS_EN so a read colliding with a same-cycle
// write to the same address returns the written bytes.
module ram32_initiator
  import ram32_pkg::*;
#(
  parameter int                      BITS     = RAM32_BITS,
  parameter logic [RAM32_DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    init_done,
  ram32_initiator_if.slave        bus,
  output logic                    EN0,
  output logic [BITS-1:0]         A0,
  output logic [RAM32_SEL_W-1:0]  WE0,
  output logic [RAM32_DATA_W-1:0] Di0,
  output logic                    EN1,
  output logic [BITS-1:0]         A1,
  input  logic [RAM32_DATA_W-1:0] Do1
);
  localparam logic [BITS:0] LAST = (BITS+1)'((2**BITS) - 1);

  state_t                  state, state_nxt;
  logic [BITS:0]           cnt, cnt_nxt;
  logic                    rd_fire;
  logic                    rsp_vld;
  logic [RAM32_DATA_W-1:0] rsp_hold;
  logic [RAM32_DATA_W-1:0] rsp_merged;

  // State and init counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and macro/handshake drive; RST gates everything so the
  // macro sees no enables while reset is held.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    EN0          = 1'b0;
    A0           = '0;
    WE0          = '0;
    Di0          = '0;
    EN1          = 1'b0;
    A1           = '0;
    bus.wr_ready = 1'b0;
    bus.rd_ready = 1'b0;
    if (!RST) begin
      case (state)
        ST_INIT: begin
          EN0     = 1'b1;
          WE0     = '1;
          A0      = cnt[BITS-1:0];
          Di0     = INIT_VAL;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          bus.wr_ready = 1'b1;
          bus.rd_ready = 1'b1;
          if (bus.wr_valid) begin
            EN0 = 1'b1;
            A0  = bus.wr_addr;
            WE0 = bus.wr_sel;
            Di0 = bus.wr_data;
          end
          if (bus.rd_valid) begin
            EN1 = 1'b1;
            A1  = bus.rd_addr;
          end
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  assign init_done = (state == ST_RUN);
  assign rd_fire   = bus.rd_valid & bus.rd_ready;

  // Response pulse one cycle after an accepted read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rsp_vld <= 1'b0;
    else     rsp_vld <= rd_fire;
  end

  // Keep the last delivered data so rsp_data stays put between pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          rsp_hold <= '0;
    else if (rsp_vld) rsp_hold <= rsp_merged;
  end

`ifdef RAM32_WR_BYPASS_EN
  logic wr_hit;
  assign wr_hit = bus.wr_valid & bus.wr_ready & rd_fire &
                  (bus.wr_addr == bus.rd_addr);

  ram32_bypass_merge u_merge (
    .CLK    (CLK),
    .RST    (RST),
    .hit    (wr_hit),
    .sel    (bus.wr_sel),
    .data   (bus.wr_data),
    .rdata  (Do1),
    .merged (rsp_merged)
  );
`else
  // Raw macro behaviour: a colliding read returns the old contents.
  assign rsp_merged = Do1;
`endif

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_data  = rsp_vld ? rsp_merged : rsp_hold;
endmodule

// File: tb/tb_ram32_initiator.sv
// Directed bench for ram32_initiator with a behavioural RAM responder and a
// scoreboard of expected read responses.
module tb_ram32_initiator;
  localparam int BITS = 5;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        init_done;
  logic        EN0, EN1;
  logic [4:0]  A0, A1;
  logic [7:0]  WE0;
  logic [63:0] Di0, Do1;

  logic [63:0] mem    [32];
  logic [63:0] shadow [32];
  exp_t        sb[$];
  logic [63:0] last_rsp = '0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  ram32_initiator_if #(.BITS(BITS)) bus ();

  ram32_initiator #(.BITS(BITS), .INIT_VAL(64'h0)) dut (
    .CLK(CLK), .RST(RST), .init_done(init_done), .bus(bus),
    .EN0(EN0), .A0(A0), .WE0(WE0), .Di0(Di0),
    .EN1(EN1), .A1(A1), .Do1(Do1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Behavioural macro: port 1 registered read (old data on collision),
  // port 0 byte-enabled write.
  always @(posedge CLK) begin
    if (EN1) Do1 <= mem[A1];
    if (EN0)
      for (int b = 0; b < 8; b++)
        if (WE0[b]) mem[A0][8*b +: 8] <= Di0[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response checker and scoreboard producer.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.rsp_valid) begin
        chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_latency", 64'(cyc), 64'(e.due));
          last_rsp = e.data;
        end
      end else begin
        chk("rsp_hold", bus.rsp_data, last_rsp);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        logic [63:0] ex;
        ex = shadow[bus.rd_addr];
`ifdef RAM32_WR_BYPASS_EN
        if (bus.wr_valid && bus.wr_ready && bus.wr_addr == bus.rd_addr)
          for (int b = 0; b < 8; b++)
            if (bus.wr_sel[b]) ex[8*b +: 8] = bus.wr_data[8*b +: 8];
`endif
        sb.push_back('{ex, cyc + 1});
      end
      if (bus.wr_valid && bus.wr_ready)
        for (int b = 0; b < 8; b++)
          if (bus.wr_sel[b]) shadow[bus.wr_addr][8*b +: 8] = bus.wr_data[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_req();
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_sel = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) shadow[i] = 64'h0;
    sb.delete();
    last_rsp = '0;
  endtask

  task automatic init_phase(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      chk({tag, "_en0"}, 64'(EN0), 64'd1);
      chk({tag, "_we0"}, 64'(WE0), 64'hFF);
      chk({tag, "_a0"}, 64'(A0), 64'(k));
      chk({tag, "_di0"}, Di0, 64'h0);
      chk({tag, "_done"}, 64'(init_done), 64'd0);
      chk({tag, "_rdy"}, 64'(bus.rd_ready), 64'd0);
      chk({tag, "_en1"}, 64'(EN1), 64'd0);
      step();
    end
  endtask

  logic [63:0] pat;

  initial begin
    idle_req();
    clear_model();

    // Reset values.
    @(negedge CLK);
    chk("rst_en0", 64'(EN0), 64'd0);
    chk("rst_we0", 64'(WE0), 64'd0);
    chk("rst_en1", 64'(EN1), 64'd0);
    chk("rst_done", 64'(init_done), 64'd0);
    chk("rst_rspv", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rspd", bus.rsp_data, 64'h0);
    @(posedge CLK); #1 RST = 1'b0;

    // Full initialisation sweep, then init_done on cycle 33.
    init_phase(32, "init");
    @(negedge CLK);
    chk("done_rise", 64'(init_done), 64'd1);
    chk("run_wrdy", 64'(bus.wr_ready), 64'd1);

    // Read of an initialised entry.
    bus.rd_valid = 1'b1; bus.rd_addr = 5'd7;
    @(negedge CLK);
    chk("rd7_en1", 64'(EN1), 64'd1);
    chk("rd7_a1", 64'(A1), 64'd7);
    step(); idle_req();
    @(negedge CLK);
    chk("rd7_rspv", 64'(bus.rsp_valid), 64'd1);
    chk("rd7_data", bus.rsp_data, 64'h0);
    step();

    // Full write then read-after-write next cycle.
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd3; bus.wr_sel = 8'hFF;
    bus.wr_data = 64'h0123_4567_89AB_CDEF;
    @(negedge CLK);
    chk("wr3_en0", 64'(EN0), 64'd1);
    chk("wr3_a0", 64'(A0), 64'd3);
    chk("wr3_we0", 64'(WE0), 64'hFF);
    chk("wr3_di0", Di0, 64'h0123_4567_89AB_CDEF);
    step(); idle_req();
    bus.rd_valid = 1'b1; bus.rd_addr = 5'd3;
    step(); idle_req();
    @(negedge CLK);
    chk("rd3_data", bus.rsp_data, 64'h0123_4567_89AB_CDEF);
    step(); step();
    @(negedge CLK);
    chk("rd3_hold", bus.rsp_data, 64'h0123_4567_89AB_CDEF);

    // Partial write on the low four bytes.
    step();
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd3; bus.wr_sel = 8'h0F;
    bus.wr_data = 64'hFFFF_FFFF_1111_2222;
    step(); idle_req();
    bus.rd_valid = 1'b1; bus.rd_addr = 5'd3;
    step(); idle_req();
    @(negedge CLK);
    chk("part_data", bus.rsp_data, 64'h0123_4567_1111_2222);
    step();

    // Same-cycle write and read to the same address.
    bus.wr_valid = 1'b1; bus.wr_addr = 5'd5; bus.wr_sel = 8'hF0;
    bus.wr_data = 64'hAAAA_BBBB_0000_0000;
    bus.rd_valid = 1'b1; bus.rd_addr = 5'd5;
    step(); idle_req();
    @(negedge CLK);
`ifdef RAM32_WR_BYPASS_EN
    chk("coll_data", bus.rsp_data, 64'hAAAA_BBBB_0000_0000);
`else
    chk("coll_data", bus.rsp_data, 64'h0);
`endif
    step();

    // Distinct writes to 0..3, an empty-select write, then streamed reads.
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 5'(i); bus.wr_sel = 8'hFF;
      bus.wr_data = {8{8'(8'h10 + i)}};
      step();
    end
    bus.wr_addr = 5'd2; bus.wr_sel = 8'h00; bus.wr_data = '1;
    @(negedge CLK);
    chk("sel0_en0", 64'(EN0), 64'd1);
    chk("sel0_we0", 64'(WE0), 64'd0);
    step(); idle_req();
    for (int i = 0; i < 5; i++) begin
      bus.rd_valid = (i < 4); bus.rd_addr = 5'(i % 4);
      @(negedge CLK);
      if (i > 0) begin
        pat = {8{8'(8'h10 + i - 1)}};
        chk("stream_v", 64'(bus.rsp_valid), 64'd1);
        chk("stream_d", bus.rsp_data, pat);
      end
      step();
    end
    idle_req();
    step();

    // Reset while a response is outstanding: it must vanish.
    bus.rd_valid = 1'b1; bus.rd_addr = 5'd1;
    step(); idle_req();
    RST = 1'b1;
    clear_model();
    #1;
    chk("rrst_rspv", 64'(bus.rsp_valid), 64'd0);
    chk("rrst_rspd", bus.rsp_data, 64'h0);
    chk("rrst_done", 64'(init_done), 64'd0);
    chk("rrst_en0", 64'(EN0), 64'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // Reset at init cycle 10 with a read held pending throughout.
    bus.rd_valid = 1'b1; bus.rd_addr = 5'd2;
    init_phase(10, "pre");
    RST = 1'b1;
    #1;
    chk("mid_en0", 64'(EN0), 64'd0);
    chk("mid_done", 64'(init_done), 64'd0);
    @(posedge CLK); #1 RST = 1'b0;
    init_phase(32, "reinit");
    @(negedge CLK);
    chk("re_done", 64'(init_done), 64'd1);
    chk("re_en1", 64'(EN1), 64'd1);
    chk("re_a1", 64'(A1), 64'd2);
    step(); idle_req();
    @(negedge CLK);
    chk("re_rspv", 64'(bus.rsp_valid), 64'd1);
    chk("re_data", bus.rsp_data, 64'h0);
    step(); step();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
